// File: rtl/de0_nano_cmd_pkg.sv
// Shared types and defaults for the DE0-Nano serial command receiver.
package de0_nano_cmd_pkg;

    localparam int unsigned CMD_W      = 8;
    localparam int unsigned DEF_CLK_HZ = 50_000_000;
    localparam int unsigned DEF_BAUD   = 115_200;
    localparam int unsigned ST_W       = 3;
    localparam int unsigned BIT_W      = 3;

    typedef enum logic [ST_W-1:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4,
        ST_BREAK  = 3'd5
    } rx_state_e;

endpackage

// File: rtl/cmd_rx_sync.sv
// Metastability synchroniser for rxd plus a registered falling-edge detect
// aligned with the first low cycle of rx_s.
module cmd_rx_sync #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset_n,
    input  logic rxd,
    output logic rx_s,
    output logic rx_fall
);

    logic [SYNC_STAGES-1:0] sync_q;

    // Flops preset high so reset release never looks like a start edge
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q  <= '1;
            rx_fall <= 1'b0;
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], rxd};
            rx_fall <= sync_q[SYNC_STAGES-1] & ~sync_q[SYNC_STAGES-2];
        end
    end

    assign rx_s = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/de0_nano_cmd_uart_rx.sv
// Serial command receiver (8N1, LSB first) holding the last good byte for the PIO.
// Define CMD_RX_PARITY_EN to add an odd-parity bit (8O1) checked before the stop bit.
module de0_nano_cmd_uart_rx
    import de0_nano_cmd_pkg::*;
#(
    parameter int unsigned CLK_HZ       = DEF_CLK_HZ,
    parameter int unsigned BAUD         = DEF_BAUD,
    parameter int unsigned CLKS_PER_BIT = CLK_HZ / BAUD,
    parameter int unsigned SYNC_STAGES  = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             rxd,
    output logic [CMD_W-1:0] cmd_out,
    output logic             cmd_strobe,
    output logic             frame_err,
    output logic [7:0]       cmd_count,
    output logic [7:0]       err_count,
    output logic             busy
);

    localparam int unsigned TICK_W = $clog2(CLKS_PER_BIT);
    localparam logic [TICK_W-1:0] TICK_HALF = TICK_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [TICK_W-1:0] TICK_FULL = TICK_W'(CLKS_PER_BIT - 1);

    logic rx_s;
    logic rx_fall;

    rx_state_e          state_q, state_n;
    logic [TICK_W-1:0]  tick_q, tick_n;
    logic [BIT_W-1:0]   bit_q, bit_n;
    logic [CMD_W-1:0]   shift_q, shift_n;
    logic               strobe_n;
    logic               err_n;
    logic               bad_frame_c;
`ifdef CMD_RX_PARITY_EN
    logic               perr_q, perr_n;
`endif

    cmd_rx_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .rxd     (rxd),
        .rx_s    (rx_s),
        .rx_fall (rx_fall)
    );

    // Next-state, bit timing and shift register update
    always_comb begin
        state_n     = state_q;
        tick_n      = tick_q + TICK_W'(1);
        bit_n       = bit_q;
        shift_n     = shift_q;
        strobe_n    = 1'b0;
        err_n       = 1'b0;
        bad_frame_c = 1'b0;
`ifdef CMD_RX_PARITY_EN
        perr_n      = perr_q;
`endif
        case (state_q)
            ST_IDLE: begin
                tick_n = '0;
                if (rx_fall) begin
                    state_n = ST_START;
                    bit_n   = '0;
`ifdef CMD_RX_PARITY_EN
                    perr_n  = 1'b0;
`endif
                end
            end
            ST_START: begin
                if (tick_q == TICK_HALF) begin
                    tick_n  = '0;
                    state_n = rx_s ? ST_IDLE : ST_DATA;
                end
            end
            ST_DATA: begin
                if (tick_q == TICK_FULL) begin
                    tick_n  = '0;
                    shift_n = {rx_s, shift_q[CMD_W-1:1]};
                    bit_n   = bit_q + BIT_W'(1);
                    if (bit_q == BIT_W'(CMD_W - 1)) begin
`ifdef CMD_RX_PARITY_EN
                        state_n = ST_PARITY;
`else
                        state_n = ST_STOP;
`endif
                    end
                end
            end
`ifdef CMD_RX_PARITY_EN
            ST_PARITY: begin
                // Odd parity: data plus parity bit must hold an odd number of ones
                if (tick_q == TICK_FULL) begin
                    tick_n  = '0;
                    perr_n  = ~(^{shift_q, rx_s});
                    state_n = ST_STOP;
                end
            end
`endif
            ST_STOP: begin
                if (tick_q == TICK_FULL) begin
                    tick_n = '0;
`ifdef CMD_RX_PARITY_EN
                    bad_frame_c = ~rx_s | perr_q;
`else
                    bad_frame_c = ~rx_s;
`endif
                    err_n    = bad_frame_c;
                    strobe_n = ~bad_frame_c;
                    state_n  = rx_s ? ST_IDLE : ST_BREAK;
                end
            end
            ST_BREAK: begin
                tick_n = '0;
                if (rx_s) begin
                    state_n = ST_IDLE;
                end
            end
            default: begin
                tick_n  = '0;
                state_n = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            tick_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
`ifdef CMD_RX_PARITY_EN
            perr_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_n;
            tick_q  <= tick_n;
            bit_q   <= bit_n;
            shift_q <= shift_n;
`ifdef CMD_RX_PARITY_EN
            perr_q  <= perr_n;
`endif
        end
    end

    // Held command register, status pulses and frame counters
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cmd_out    <= '0;
            cmd_strobe <= 1'b0;
            frame_err  <= 1'b0;
            cmd_count  <= '0;
            err_count  <= '0;
            busy       <= 1'b0;
        end else begin
            cmd_strobe <= strobe_n;
            frame_err  <= err_n;
            busy       <= (state_n != ST_IDLE);
            if (strobe_n) begin
                cmd_out   <= shift_q;
                cmd_count <= cmd_count + 8'd1;
            end
            if (err_n && (err_count != 8'hFF)) begin
                err_count <= err_count + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_de0_nano_cmd_uart_rx.sv
// Directed bench for the serial command receiver, 256 clocks per bit.
module tb_de0_nano_cmd_uart_rx;

    localparam int unsigned CPB = 256;
`ifdef CMD_RX_PARITY_EN
    localparam int unsigned LAT = 10 * CPB + CPB / 2 + 3;
`else
    localparam int unsigned LAT = 9 * CPB + CPB / 2 + 3;
`endif

    logic       clk = 1'b0;
    logic       reset_n;
    logic       rxd;
    logic [7:0] cmd_out;
    logic       cmd_strobe;
    logic       frame_err;
    logic [7:0] cmd_count;
    logic [7:0] err_count;
    logic       busy;

    int unsigned cyc = 0;
    int unsigned strobe_cnt = 0;
    int unsigned err_pulse_cnt = 0;
    int unsigned overlap_cnt = 0;
    int unsigned bad_update_cnt = 0;
    int unsigned last_strobe_cyc = 0;
    int unsigned passed = 0;
    int unsigned total = 0;
    int unsigned t0;
    logic [7:0] prev_cmd = 8'h00;

    de0_nano_cmd_uart_rx #(
        .CLK_HZ      (25_600_000),
        .BAUD        (100_000),
        .SYNC_STAGES (2)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .rxd        (rxd),
        .cmd_out    (cmd_out),
        .cmd_strobe (cmd_strobe),
        .frame_err  (frame_err),
        .cmd_count  (cmd_count),
        .err_count  (err_count),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // Pulse bookkeeping, sampled away from the active edge
    always @(negedge clk) begin
        if (cmd_strobe === 1'b1) begin
            strobe_cnt++;
            last_strobe_cyc = cyc;
        end
        if (frame_err === 1'b1) err_pulse_cnt++;
        if (cmd_strobe === 1'b1 && frame_err === 1'b1) overlap_cnt++;
        if (reset_n === 1'b1 && cmd_out !== prev_cmd && cmd_strobe !== 1'b1) bad_update_cnt++;
        prev_cmd = cmd_out;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic clks(input int unsigned n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bit(input logic b);
        rxd = b;
        clks(CPB);
    endtask

    task automatic send_byte(input logic [7:0] d, input logic stop_bit);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
`ifdef CMD_RX_PARITY_EN
        send_bit(~^d);
`endif
        send_bit(stop_bit);
    endtask

`ifdef CMD_RX_PARITY_EN
    task automatic send_with_par(input logic [7:0] d, input logic par_bit);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
        send_bit(par_bit);
        send_bit(1'b1);
    endtask
`endif

    initial begin
        reset_n = 1'b0;
        rxd     = 1'b1;
        clks(5);
        chk("rst_cmd_out", 32'(cmd_out), 32'h00);
        chk("rst_strobe", 32'(cmd_strobe), 32'h0);
        chk("rst_frame_err", 32'(frame_err), 32'h0);
        chk("rst_cmd_count", 32'(cmd_count), 32'h00);
        chk("rst_err_count", 32'(err_count), 32'h00);
        chk("rst_busy", 32'(busy), 32'h0);
        reset_n = 1'b1;
        clks(5);

        // 1: single good frame and its latency
        t0 = cyc;
        send_byte(8'h5A, 1'b1);
        clks(4);
        chk("t1_cmd_out", 32'(cmd_out), 32'h5A);
        chk("t1_strobes", strobe_cnt, 32'd1);
        chk("t1_latency", last_strobe_cyc - t0, LAT);
        chk("t1_cmd_count", 32'(cmd_count), 32'd1);
        chk("t1_busy", 32'(busy), 32'h0);
        chk("t1_err_count", 32'(err_count), 32'd0);

        // 2: short low glitch is dropped at the start-bit sample
        rxd = 1'b0;
        clks(100);
        chk("t2_busy_start", 32'(busy), 32'h1);
        rxd = 1'b1;
        clks(CPB);
        chk("t2_busy_idle", 32'(busy), 32'h0);
        chk("t2_strobes", strobe_cnt, 32'd1);
        chk("t2_cmd_out", 32'(cmd_out), 32'h5A);
        chk("t2_err_pulses", err_pulse_cnt, 32'd0);

        // 3: bad stop bit holds cmd_out and parks in BREAK while the line is low
        send_byte(8'h5A, 1'b1);
        send_byte(8'hC3, 1'b0);
        clks(CPB);
        chk("t3_err_pulses", err_pulse_cnt, 32'd1);
        chk("t3_err_count", 32'(err_count), 32'd1);
        chk("t3_cmd_out", 32'(cmd_out), 32'h5A);
        chk("t3_strobes", strobe_cnt, 32'd2);
        chk("t3_cmd_count", 32'(cmd_count), 32'd2);
        chk("t3_busy_break", 32'(busy), 32'h1);
        rxd = 1'b1;
        clks(8);
        chk("t3_busy_idle", 32'(busy), 32'h0);

        // 4: back-to-back frames with no idle gap
        for (int i = 1; i <= 4; i++) send_byte(8'(i), 1'b1);
        clks(4);
        chk("t4_strobes", strobe_cnt, 32'd6);
        chk("t4_cmd_out", 32'(cmd_out), 32'h04);
        chk("t4_cmd_count", 32'(cmd_count), 32'd6);
        chk("t4_err_count", 32'(err_count), 32'd1);

        // 5: reset during bit 4 of 0xFF, then a clean frame
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'b1);
        rxd = 1'b1;
        clks(CPB / 2);
        reset_n = 1'b0;
        clks(2);
        chk("t5_cmd_out", 32'(cmd_out), 32'h00);
        chk("t5_cmd_count", 32'(cmd_count), 32'd0);
        chk("t5_err_count", 32'(err_count), 32'd0);
        chk("t5_busy", 32'(busy), 32'h0);
        chk("t5_strobe", 32'(cmd_strobe), 32'h0);
        chk("t5_frame_err", 32'(frame_err), 32'h0);
        clks(CPB);
        reset_n = 1'b1;
        clks(CPB);
        send_byte(8'h33, 1'b1);
        clks(4);
        chk("t5_rx_cmd_out", 32'(cmd_out), 32'h33);
        chk("t5_rx_cmd_count", 32'(cmd_count), 32'd1);
        chk("t5_rx_strobes", strobe_cnt, 32'd7);
        chk("t5_rx_err_count", 32'(err_count), 32'd0);

`ifdef CMD_RX_PARITY_EN
        // 6: 0x07 has three ones, so the odd-parity bit must be 0
        send_with_par(8'h07, 1'b1);
        clks(4);
        chk("t6_bad_err_pulses", err_pulse_cnt, 32'd2);
        chk("t6_bad_err_count", 32'(err_count), 32'd1);
        chk("t6_bad_cmd_out", 32'(cmd_out), 32'h33);
        chk("t6_bad_busy", 32'(busy), 32'h0);
        send_with_par(8'h07, 1'b0);
        clks(4);
        chk("t6_good_cmd_out", 32'(cmd_out), 32'h07);
        chk("t6_good_cmd_count", 32'(cmd_count), 32'd2);
        chk("t6_good_strobes", strobe_cnt, 32'd8);
`endif

        chk("strobe_err_overlap", overlap_cnt, 32'd0);
        chk("cmd_out_without_strobe", bad_update_cnt, 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
